multisim_pull_arbiter: RTL

- Merges N valid/ready pull streams, each from one multisim client pull instance, into a single registered output stream.
- Grants are round-robin with an optional per-channel burst lock.
- Sits between the per-server client pull instances and one shared consumer, e.g. a single DUT input port or transaction decoder.
- Each output beat is tagged with its source channel index.

---
 rtl/multisim_pull_arbiter_if.sv | 27 ++
 rtl/multisim_pull_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/multisim_pull_arbiter_if.sv
// Handshake bundle between N client pull streams and the merged output stream.
// The arbiter connects through the slave modport; the environment driving the
// input streams and consuming the output connects through the master modport.
interface multisim_pull_arbiter_if #(
  parameter int N_CHANNELS = 4,
  parameter int DATA_WIDTH = 64
);
  localparam int ID_WIDTH = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  logic [N_CHANNELS-1:0]            in_vld;
  logic [N_CHANNELS-1:0]            in_rdy;
  logic [N_CHANNELS*DATA_WIDTH-1:0] in_data;
  logic                             out_vld;
  logic                             out_rdy;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [ID_WIDTH-1:0]              out_id;

  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data, out_id
  );

  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data, out_id
  );
endinterface

// File: rtl/multisim_pull_arbiter.sv
// Round-robin merge of N valid/ready pull streams into one registered output
// stream tagged with the source channel index. An optional burst lock keeps
// the grant on one channel for up to MAX_BURST consecutive beats.
module multisim_pull_arbiter #(
  parameter int N_CHANNELS = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  multisim_pull_arbiter_if.slave bus
);
  localparam int ID_WIDTH = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  logic                  out_vld_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [ID_WIDTH-1:0]   out_id_reg;
  logic [ID_WIDTH-1:0]   last_grant_reg;
  logic [7:0]            burst_cnt_reg;
  logic                  lock_reg;

  logic                  load_en;
  logic                  grant_vld;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [7:0]            burst_cnt_next;
  logic [N_CHANNELS-1:0] in_rdy_next;
  logic [DATA_WIDTH-1:0] chan_data [N_CHANNELS];

  // One-entry output slice: accept a new beat whenever the slot is empty or
  // its current beat leaves this cycle.
  assign load_en = !out_vld_reg || bus.out_rdy;

  genvar gi;
  generate
    for (gi = 0; gi < N_CHANNELS; gi++) begin : g_unpack
      assign chan_data[gi] = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Grant selection: stay on the locked channel while it still has data,
  // otherwise search upward from the channel after the last grant.
  always_comb begin
    int                  pos;
    logic [ID_WIDTH-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    pos       = 0;
    cand      = '0;
    if (lock_reg && bus.in_vld[last_grant_reg]) begin
      grant_vld = 1'b1;
      grant_idx = last_grant_reg;
    end else begin
      for (int k = 1; k <= N_CHANNELS; k++) begin
        pos = int'(last_grant_reg) + k;
        if (pos >= N_CHANNELS) pos = pos - N_CHANNELS;
        cand = ID_WIDTH'(pos);
        if (!grant_vld && bus.in_vld[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // Accept strobe back to the granted producer, held low while in reset.
  always_comb begin
    in_rdy_next = '0;
    if (rst_n && load_en && grant_vld) in_rdy_next[grant_idx] = 1'b1;
  end

  // Burst length continues only when the locked channel is granted again.
  always_comb begin
    burst_cnt_next = 8'd1;
    if (lock_reg && (grant_idx == last_grant_reg)) burst_cnt_next = burst_cnt_reg + 8'd1;
  end

  // Output register, grant pointer and burst state; everything holds while the
  // consumer stalls a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_reg    <= 1'b0;
      out_data_reg   <= '0;
      out_id_reg     <= '0;
      last_grant_reg <= ID_WIDTH'(N_CHANNELS - 1);
      burst_cnt_reg  <= '0;
      lock_reg       <= 1'b0;
    end else if (load_en) begin
      if (grant_vld) begin
        out_vld_reg    <= 1'b1;
        out_data_reg   <= chan_data[grant_idx];
        out_id_reg     <= grant_idx;
        last_grant_reg <= grant_idx;
        burst_cnt_reg  <= burst_cnt_next;
        lock_reg       <= (burst_cnt_next < 8'(MAX_BURST));
      end else begin
        out_vld_reg <= 1'b0;
        lock_reg    <= 1'b0;
      end
    end
  end

  assign bus.in_rdy   = in_rdy_next;
  assign bus.out_vld  = out_vld_reg;
  assign bus.out_data = out_data_reg;
  assign bus.out_id   = out_id_reg;

endmodule
